// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: 15-entry register file, sticky status latch, retire counter.
// Define WB_BYPASS_EN to make same-cycle commits visible on the decode read ports.
module writeback_regfile #(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valE,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       Stat,
  output logic             cpu_halt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [3:0] IcodeNop = 4'h1;

  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];
  logic [2:0]       stat_q, stat_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  assign commit = (W_stat == StatAok) && !halt_q;

  always_comb begin
    regs_d = regs_q;
    stat_d = stat_q;
    halt_d = halt_q;
    cnt_d  = cnt_q;
    if (commit) begin
      // M written last so it wins when both destinations name the same register
      if (W_dstE != RegNone) regs_d[W_dstE] = W_valE;
      if (W_dstM != RegNone) regs_d[W_dstM] = W_valM;
      if (W_icode != IcodeNop) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (!halt_q && (W_stat != StatAok)) begin
      stat_d = W_stat;
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
      stat_q <= StatAok;
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      stat_q <= stat_d;
      halt_q <= halt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    d_rvalA = 64'h0;
    d_rvalB = 64'h0;
    if (d_srcA != RegNone) d_rvalA = regs_q[d_srcA];
    if (d_srcB != RegNone) d_rvalB = regs_q[d_srcB];
`ifdef WB_BYPASS_EN
    if (commit && (d_srcA != RegNone)) begin
      if (d_srcA == W_dstE) d_rvalA = W_valE;
      if (d_srcA == W_dstM) d_rvalA = W_valM;
    end
    if (commit && (d_srcB != RegNone)) begin
      if (d_srcB == W_dstE) d_rvalB = W_valE;
      if (d_srcB == W_dstM) d_rvalB = W_valM;
    end
`else
`endif
  end

  assign Stat       = stat_q;
  assign cpu_halt   = halt_q;
  assign retire_cnt = cnt_q;

endmodule
